// File: rtl/tt_checker.sv
// tt_checker: exhaustive truth-table checker for a 2-input combinational DUT.
// It walks minterms 0..3 on x/y and waits SETTLE cycles per minterm. It then
// samples dut_s against a latched golden table and counts mismatches.
// Optional feature: define TT_CHECKER_FAIL_MASK_EN to add the fail_mask output.
module tt_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] expected,
  input  logic       dut_s,
  output logic       x,
  output logic       y,
  output logic [1:0] minterm,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count
`ifdef TT_CHECKER_FAIL_MASK_EN
  ,
  output logic [3:0] fail_mask
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       mt_next;
  logic [3:0]       exp_q, exp_next;
  logic [2:0]       err_next;
  logic             mismatch;
`ifdef TT_CHECKER_FAIL_MASK_EN
  logic [3:0]       mask_next;
`endif

  // Next-state and datapath update; x/y only move on start or SAMPLE exit.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mt_next    = minterm;
    exp_next   = exp_q;
    err_next   = err_count;
    mismatch   = (dut_s != exp_q[minterm]);
`ifdef TT_CHECKER_FAIL_MASK_EN
    mask_next  = fail_mask;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          exp_next   = expected;
          err_next   = 3'd0;
          mt_next    = 2'd0;
          cnt_next   = '0;
`ifdef TT_CHECKER_FAIL_MASK_EN
          mask_next  = 4'd0;
`endif
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        cnt_next = cnt + 4'd1;
        if (cnt == SETTLE_LAST) state_next = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch) begin
          err_next = err_count + 3'd1;
`ifdef TT_CHECKER_FAIL_MASK_EN
          mask_next[minterm] = 1'b1;
`endif
        end
        if (minterm != 2'd3) begin
          mt_next    = minterm + 2'd1;
          cnt_next   = '0;
          state_next = DRIVE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs; status flags reflect the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      minterm   <= 2'd0;
      x         <= 1'b0;
      y         <= 1'b0;
      exp_q     <= 4'd0;
      err_count <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
`ifdef TT_CHECKER_FAIL_MASK_EN
      fail_mask <= 4'd0;
`endif
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      minterm   <= mt_next;
      x         <= mt_next[1];
      y         <= mt_next[0];
      exp_q     <= exp_next;
      err_count <= err_next;
      busy      <= (state_next == DRIVE) || (state_next == SAMPLE);
      done      <= (state_next == DONE);
      pass      <= (state_next == DONE) && (err_next == 3'd0);
`ifdef TT_CHECKER_FAIL_MASK_EN
      fail_mask <= mask_next;
`endif
    end
  end

endmodule

// File: doc/tt_checker.md
TT_CHECKER -- requirements
Module: tt_checker

Interface
REQ-001 Parameter SETTLE, default 1, DRIVE cycles per minterm before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  run request; sampled in IDLE or DONE only.
REQ-005 expected  input  4  golden truth table; bit m = required DUT output for minterm m ({x,y}=m).
REQ-006 dut_s  input  1  combinational response of 2-input DUT under test.
REQ-007 x  output  1  DUT input a (minterm bit 1), registered.
REQ-008 y  output  1  DUT input b (minterm bit 0), registered.
REQ-009 minterm  output  2  index currently applied.
REQ-010 busy  output  1  high in DRIVE or SAMPLE.
REQ-011 done  output  1  high in DONE; held until next start or reset.
REQ-012 pass  output  1  high in DONE when err_count==0; low elsewhere.
REQ-013 err_count  output  3  mismatches in current/last run, 0..4.

Function
REQ-014 FSM states IDLE, DRIVE, SAMPLE, DONE, binary encoded.
REQ-015 IDLE or DONE with start=1: latch expected, clear err_count, minterm=0, x=0, y=0, settle counter=0; next DRIVE.
REQ-016 DRIVE: settle counter increments each cycle; when counter==SETTLE-1, next SAMPLE.
REQ-017 SAMPLE (one cycle): compare dut_s to latched expected[minterm]; mismatch increments err_count at the exiting edge.
REQ-018 SAMPLE exit, minterm<3: minterm+1, x/y update to new minterm, counter cleared, next DRIVE.
REQ-019 SAMPLE exit, minterm==3: next DONE; minterm, x, y hold at 3/1/1.
REQ-020 Run length: DONE entered exactly 4*(SETTLE+1) cycles after the start-sampling edge.
REQ-021 x, y stable throughout each DRIVE+SAMPLE window; no glitch between minterms except at the SAMPLE exit edge.
REQ-022 start while busy ignored; expected changes while busy ignored (latched copy used).
REQ-023 start in DONE restarts per REQ-015; done and pass drop on that same edge.
REQ-024 err_count saturates by construction at 4; never wraps.

Reset
REQ-025 rst_n low, any state, immediately: state=IDLE, x=0, y=0, minterm=0, busy=0, done=0, pass=0, err_count=0, counter=0, latched expected=0.
REQ-026 Reset mid-run aborts without reaching DONE; first start after rst_n rises begins a fresh run.

Configuration
REQ-027 Macro TT_CHECKER_FAIL_MASK_EN defined: extra output fail_mask [3:0], bit m set when minterm m mismatched; cleared on reset and on start; valid in DONE.
REQ-028 Macro TT_CHECKER_FAIL_MASK_EN undefined: fail_mask port and logic absent; all other behaviour identical.

Verification
REQ-029 SETTLE=1, NAND DUT, expected=4'b0111, start pulse -> done high 8 cycles later, err_count=0, pass=1, x/y sequence 00,01,10,11 each 2 cycles.
REQ-030 NAND DUT, expected=4'b0010 (a'.b) -> err_count=2, pass=0; with macro fail_mask=4'b0101.
REQ-031 NAND DUT, expected=4'b1000 -> err_count=4, pass=0; with macro fail_mask=4'b1111.
REQ-032 SETTLE=3, matching table -> done 16 cycles after start; each minterm held 4 cycles; start pulses mid-run have no effect.
REQ-033 rst_n low during minterm 2 -> all outputs reset values asynchronously; rst_n high, start -> full 8-cycle run, err_count reflects only the new run.
REQ-034 In DONE, start with new expected -> done/pass drop on that edge, second run completes with fresh err_count.
